spi_cfg_loader: RTL
===================

Name: spi_cfg_loader

Overview:
Command front-end between the UART receiver and the SPI master. Assembles framed configuration words from received UART bytes, checks them, and issues one SPI write per good frame. Sequences the write by waiting for the SPI chip-select low→high cycle, then reports done or error. Also decodes a one-byte ADC reset command so the PC can restart the ADC system over the serial link.

Parameters:
SPI_N_BIT, 96, SPI word width; must be a multiple of UART_NUM_DATA
UART_NUM_DATA, 8, UART byte width
HDR_CFG, 8'hA5, header byte that starts a configuration frame
HDR_RST, 8'h5A, single-byte ADC reset command
GAP_TIMEOUT, 4000, max clk cycles allowed between bytes inside a frame
CSN_TIMEOUT, 256, max clk cycles from spi_wreq to spi_csn falling

Ports:
clk  in  1  system clock (the clk_adc domain)
rst  in  1  synchronous reset, active-high
uart_rdata  in  UART_NUM_DATA  received byte
uart_vld  in  1  one-cycle strobe; uart_rdata is valid
spi_csn  in  1  SPI master chip-select; low while a transfer is in progress
spi_wreq  out  1  one-cycle write request to the SPI master
spi_wdata  out  SPI_N_BIT  word to transmit; held stable until the next frame is accepted
cfg_busy  out  1  high in every state except IDLE
cfg_done  out  1  one-cycle pulse when the SPI transfer completes
cfg_err  out  1  one-cycle pulse on any error
err_code  out  2  last error: 0 none, 1 checksum, 2 gap timeout, 3 csn timeout; holds until the next error or reset
adc_rst_req  out  1  one-cycle pulse when HDR_RST is received in IDLE
frame_cnt  out  8  count of completed SPI writes; wraps 255→0

Behaviour:
- Reset: all outputs 0, except spi_csn-related tracking. State is IDLE, byte index is 0, and the gap timer and csn timer are cleared.
- NBYTES = SPI_N_BIT/UART_NUM_DATA (12 at the defaults).
- IDLE:
  - vld with HDR_CFG → RX_PAYLOAD, idx=0.
  - vld with HDR_RST → adc_rst_req pulses on the next cycle; state stays IDLE.
  - Any other byte is ignored silently.
- RX_PAYLOAD:
  - Each vld shifts its byte into the shadow register. The first byte lands in the MSBs, i.e. bits [SPI_N_BIT-1 -: 8].
  - A running XOR accumulates over the payload bytes.
  - After byte NBYTES-1 → RX_CSUM (or ISSUE when checksum is compiled out).
- RX_CSUM:
  - The next vld byte is compared against the XOR accumulator.
  - Match → ISSUE.
  - Mismatch → cfg_err pulses, err_code=1, state → IDLE, spi_wdata is unchanged.
- Gap timer: runs in RX_PAYLOAD and RX_CSUM, reloads on every vld. On reaching GAP_TIMEOUT: cfg_err pulses, err_code=2, state → IDLE.
- ISSUE (1 cycle):
  - spi_wdata ← shadow register.
  - spi_wreq=1 in the same cycle.
  - → WAIT_LO.
- WAIT_LO: waits for spi_csn=0.
  - csn timer counts from the cycle after spi_wreq.
  - Reaching CSN_TIMEOUT → cfg_err pulses, err_code=3, state → IDLE.
- WAIT_HI: waits for spi_csn=1. On that edge: cfg_done pulses, frame_cnt increments, state → IDLE. No timeout here because the transfer length is fixed by the SPI master.
- Latency: spi_wreq asserts exactly 1 cycle after the vld of the checksum byte (or of the last payload byte when checksum is compiled out).
- Bytes arriving in ISSUE, WAIT_LO or WAIT_HI are dropped. They do not restart a frame.
- HDR_RST inside a frame is treated as payload data.
- vld and a timeout in the same cycle: vld wins and the timer reloads.
- rst mid-transfer: returns to IDLE at once and spi_wreq deasserts. An SPI transfer already started completes on its own; this block does not track it.

Optional Feature:
CFG_CHECKSUM_EN.
- Defined: frame = header + NBYTES payload + XOR checksum byte; err_code 1 is reachable.
- Undefined: frame = header + NBYTES payload; RX_CSUM state and XOR logic are removed; err_code 1 never occurs.

Decomposition:
- Package giraffe_cfg_pkg holds:
  - state enum: IDLE, RX_PAYLOAD, RX_CSUM, ISSUE, WAIT_LO, WAIT_HI
  - err_code constants: ERR_NONE, ERR_CSUM, ERR_GAP, ERR_CSN
  - default header byte values
- One natural sub-module, cfg_timeout_ctr: a parameterised down-counter with load/enable/expire, instantiated twice (gap timer and csn timer).

Test Plan:
- Good frame: A5, 01..0C, then checksum 0x0C (XOR of 01..0C).
  - spi_wreq pulses 1 cycle after the checksum vld with wdata=0x0102…0C.
  - Drive spi_csn low for 100 cycles.
  - cfg_done pulses on csn rise; frame_cnt=1.
- Bad checksum: same payload, checksum 0x00 → cfg_err pulses, err_code=1, no spi_wreq, spi_wdata keeps its previous value.
- Gap timeout: A5, then 5 bytes, then idle for 4000 cycles → cfg_err, err_code=2, state IDLE. A following good frame is accepted normally.
- CSN timeout: good frame with spi_csn held at 1 → cfg_err 256 cycles after spi_wreq, err_code=3, frame_cnt unchanged.
- Reset command and drop rules:
  - 5A in IDLE → adc_rst_req single pulse.
  - 5A sent during WAIT_HI → no pulse and byte dropped.
  - Assert rst during WAIT_LO → all outputs 0 on the next cycle.
- Wrap: 256 good frames → frame_cnt returns to 0. Repeat the good-frame test with the build macro off: 13-byte frames are accepted.

Source files
------------

// File: rtl/giraffe_cfg_pkg.sv
// Shared types and constants for the SPI configuration loader: FSM states,
// error codes and the default header byte values.
package giraffe_cfg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_RX_PAYLOAD = 3'd1,
        ST_RX_CSUM    = 3'd2,
        ST_ISSUE      = 3'd3,
        ST_WAIT_LO    = 3'd4,
        ST_WAIT_HI    = 3'd5
    } cfg_state_e;

    localparam logic [1:0] ERR_NONE = 2'd0;
    localparam logic [1:0] ERR_CSUM = 2'd1;
    localparam logic [1:0] ERR_GAP  = 2'd2;
    localparam logic [1:0] ERR_CSN  = 2'd3;

    localparam logic [7:0] HDR_CFG_DEF = 8'hA5;
    localparam logic [7:0] HDR_RST_DEF = 8'h5A;

endpackage

// File: rtl/spi_cfg_loader_timeout_ctr.sv
// cfg_timeout_ctr: loadable down-counter. expire_o flags the last enabled
// cycle before the count runs out; a load in the same cycle always wins.
module cfg_timeout_ctr #(
    parameter int unsigned LOAD_VAL = 4000,
    parameter int unsigned WIDTH    = $clog2(LOAD_VAL + 1)
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic load_i,
    input  logic en_i,
    output logic expire_o
);

    localparam logic [WIDTH-1:0] LOAD_Q = WIDTH'(LOAD_VAL);
    localparam logic [WIDTH-1:0] ONE_Q  = WIDTH'(1);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    // Next count: reload, count down while enabled, saturate at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = LOAD_Q;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - ONE_Q;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_o = en_i && !load_i && (cnt_q <= ONE_Q);

endmodule

// File: rtl/spi_cfg_loader.sv
// spi_cfg_loader: assembles UART bytes into configuration frames and issues one SPI write per good frame.
// Build option CFG_CHECKSUM_EN appends and verifies an XOR checksum byte after the payload.
module spi_cfg_loader
    import giraffe_cfg_pkg::*;
#(
    parameter int unsigned              SPI_N_BIT     = 96,
    parameter int unsigned              UART_NUM_DATA = 8,
    parameter logic [UART_NUM_DATA-1:0] HDR_CFG       = HDR_CFG_DEF,
    parameter logic [UART_NUM_DATA-1:0] HDR_RST       = HDR_RST_DEF,
    parameter int unsigned              GAP_TIMEOUT   = 4000,
    parameter int unsigned              CSN_TIMEOUT   = 256
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [UART_NUM_DATA-1:0] uart_rdata_i,
    input  logic                     uart_vld_i,
    input  logic                     spi_csn_i,
    output logic                     spi_wreq_o,
    output logic [SPI_N_BIT-1:0]     spi_wdata_o,
    output logic                     cfg_busy_o,
    output logic                     cfg_done_o,
    output logic                     cfg_err_o,
    output logic [1:0]               err_code_o,
    output logic                     adc_rst_req_o,
    output logic [7:0]               frame_cnt_o
);

    localparam int unsigned      NBYTES   = SPI_N_BIT / UART_NUM_DATA;
    localparam int unsigned      IDX_W    = $clog2(NBYTES + 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NBYTES - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

    cfg_state_e               state_q, state_d;
    logic [IDX_W-1:0]         idx_q, idx_d;
    logic [SPI_N_BIT-1:0]     shadow_q, shadow_d;
    logic [SPI_N_BIT-1:0]     wdata_q, wdata_d;
    logic                     wreq_q, wreq_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;
    logic                     err_q, err_d;
    logic [1:0]               err_code_q, err_code_d;
    logic                     adc_rst_q, adc_rst_d;
    logic [7:0]               frame_cnt_q, frame_cnt_d;
    logic [SPI_N_BIT-1:0]     shadow_shift_s;
    logic                     gap_load_s, gap_en_s, gap_expire_s;
    logic                     csn_load_s, csn_en_s, csn_expire_s;

`ifdef CFG_CHECKSUM_EN
    logic [UART_NUM_DATA-1:0] csum_q, csum_d;

    function automatic logic [UART_NUM_DATA-1:0] csum_step(
        input logic [UART_NUM_DATA-1:0] acc,
        input logic [UART_NUM_DATA-1:0] data
    );
        return acc ^ data;
    endfunction
`endif

    // First payload byte ends up in the MSBs after NBYTES shifts.
    assign shadow_shift_s = {shadow_q[SPI_N_BIT-UART_NUM_DATA-1:0], uart_rdata_i};

    cfg_timeout_ctr #(.LOAD_VAL(GAP_TIMEOUT)) u_gap_ctr (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .load_i   (gap_load_s),
        .en_i     (gap_en_s),
        .expire_o (gap_expire_s)
    );

    // Loaded while ISSUE is active so the count starts the cycle after spi_wreq.
    cfg_timeout_ctr #(.LOAD_VAL(CSN_TIMEOUT - 1)) u_csn_ctr (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .load_i   (csn_load_s),
        .en_i     (csn_en_s),
        .expire_o (csn_expire_s)
    );

    // Frame FSM next-state and next-output logic.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        shadow_d    = shadow_q;
        wdata_d     = wdata_q;
        wreq_d      = 1'b0;
        done_d      = 1'b0;
        err_d       = 1'b0;
        err_code_d  = err_code_q;
        adc_rst_d   = 1'b0;
        frame_cnt_d = frame_cnt_q;
        gap_load_s  = 1'b0;
        gap_en_s    = 1'b0;
        csn_load_s  = 1'b0;
        csn_en_s    = 1'b0;
`ifdef CFG_CHECKSUM_EN
        csum_d      = csum_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (uart_vld_i && (uart_rdata_i == HDR_CFG)) begin
                    state_d    = ST_RX_PAYLOAD;
                    idx_d      = '0;
                    gap_load_s = 1'b1;
`ifdef CFG_CHECKSUM_EN
                    csum_d     = '0;
`endif
                end else if (uart_vld_i && (uart_rdata_i == HDR_RST)) begin
                    adc_rst_d = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RX_PAYLOAD: begin
                gap_en_s = 1'b1;
                if (uart_vld_i) begin
                    gap_load_s = 1'b1;
                    shadow_d   = shadow_shift_s;
`ifdef CFG_CHECKSUM_EN
                    csum_d     = csum_step(csum_q, uart_rdata_i);
`endif
                    if (idx_q == IDX_LAST) begin
`ifdef CFG_CHECKSUM_EN
                        state_d = ST_RX_CSUM;
`else
                        state_d = ST_ISSUE;
                        wreq_d  = 1'b1;
                        wdata_d = shadow_shift_s;
`endif
                    end else begin
                        idx_d = idx_q + IDX_ONE;
                    end
                end else if (gap_expire_s) begin
                    state_d    = ST_IDLE;
                    err_d      = 1'b1;
                    err_code_d = ERR_GAP;
                end else begin
                    state_d = ST_RX_PAYLOAD;
                end
            end
`ifdef CFG_CHECKSUM_EN
            ST_RX_CSUM: begin
                gap_en_s = 1'b1;
                if (uart_vld_i && (uart_rdata_i == csum_q)) begin
                    state_d = ST_ISSUE;
                    wreq_d  = 1'b1;
                    wdata_d = shadow_q;
                end else if (uart_vld_i) begin
                    state_d    = ST_IDLE;
                    err_d      = 1'b1;
                    err_code_d = ERR_CSUM;
                end else if (gap_expire_s) begin
                    state_d    = ST_IDLE;
                    err_d      = 1'b1;
                    err_code_d = ERR_GAP;
                end else begin
                    state_d = ST_RX_CSUM;
                end
            end
`endif
            ST_ISSUE: begin
                csn_load_s = 1'b1;
                state_d    = ST_WAIT_LO;
            end
            ST_WAIT_LO: begin
                csn_en_s = spi_csn_i;
                if (!spi_csn_i) begin
                    state_d = ST_WAIT_HI;
                end else if (csn_expire_s) begin
                    state_d    = ST_IDLE;
                    err_d      = 1'b1;
                    err_code_d = ERR_CSN;
                end else begin
                    state_d = ST_WAIT_LO;
                end
            end
            ST_WAIT_HI: begin
                if (spi_csn_i) begin
                    state_d     = ST_IDLE;
                    done_d      = 1'b1;
                    frame_cnt_d = frame_cnt_q + 8'd1;
                end else begin
                    state_d = ST_WAIT_HI;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // State and registered outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            shadow_q    <= '0;
            wdata_q     <= '0;
            wreq_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            err_code_q  <= ERR_NONE;
            adc_rst_q   <= 1'b0;
            frame_cnt_q <= 8'd0;
`ifdef CFG_CHECKSUM_EN
            csum_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            shadow_q    <= shadow_d;
            wdata_q     <= wdata_d;
            wreq_q      <= wreq_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            err_code_q  <= err_code_d;
            adc_rst_q   <= adc_rst_d;
            frame_cnt_q <= frame_cnt_d;
`ifdef CFG_CHECKSUM_EN
            csum_q      <= csum_d;
`endif
        end
    end

    assign spi_wreq_o    = wreq_q;
    assign spi_wdata_o   = wdata_q;
    assign cfg_busy_o    = busy_q;
    assign cfg_done_o    = done_q;
    assign cfg_err_o     = err_q;
    assign err_code_o    = err_code_q;
    assign adc_rst_req_o = adc_rst_q;
    assign frame_cnt_o   = frame_cnt_q;

endmodule
